// File: rtl/finv_arbiter.sv
// Round-robin share of one pipelined finv unit among N_REQ requesters, result routed back by id.
// Latency: gnt is combinational in the request cycle; res_valid arrives LATENCY cycles after issue.
// Backpressure: a requester holds req/x_in until gnt; one op per requester in flight; results are never stalled.
//
// Ports:
//   clk, rstn            clock, async active-low reset
//   req[N_REQ]           request strobes; x_in[32*i +: 32] carries requester i's operand
//   gnt[N_REQ]           one-hot issue acknowledge (same cycle as req)
//   busy[N_REQ]          requester has an op in flight
//   finv_x / finv_y      operand to / result from the shared finv instance
//   res_valid[N_REQ]     one-hot single-cycle result strobe; res_y carries the data
// Optional: define FINV_ARB_PERF_EN to add perf_issue / perf_conflict counters.
module finv_arbiter #(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 3,
    parameter int IDW     = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N_REQ-1:0]     req,
    input  logic [32*N_REQ-1:0]  x_in,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     busy,
    output logic [31:0]          finv_x,
    input  logic [31:0]          finv_y,
    output logic [N_REQ-1:0]     res_valid,
    output logic [31:0]          res_y
`ifdef FINV_ARB_PERF_EN
    ,
    output logic [31:0]          perf_issue,
    output logic [31:0]          perf_conflict
`endif
);

    logic [N_REQ-1:0]   r_busy;
    logic [IDW-1:0]     r_rr_ptr;
    // Shadow pipe: one {vld,id} slot per finv pipeline stage, last slot lines up with finv_y.
    logic [LATENCY-1:0] r_sh_vld;
    logic [IDW-1:0]     r_sh_id [LATENCY];

    logic [N_REQ-1:0]   w_elig;
    logic [N_REQ-1:0]   w_gnt;
    logic [N_REQ-1:0]   w_ret;
    logic               w_issue;
    logic [IDW-1:0]     w_gnt_id;
    logic [IDW-1:0]     w_rr_nxt;
    int                 w_idx;

    assign w_elig = req & ~r_busy;

    // Rotating-priority search starting at r_rr_ptr. Gated by rstn so that
    // nothing is acknowledged while the block is held in reset.
    always_comb begin
        w_issue  = 1'b0;
        w_gnt_id = '0;
        w_idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = (int'(r_rr_ptr) + k) % N_REQ;
            if (rstn && !w_issue && w_elig[w_idx]) begin
                w_issue  = 1'b1;
                w_gnt_id = IDW'(w_idx);
            end
        end
    end

    always_comb begin
        w_gnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_issue && (w_gnt_id == IDW'(i))) begin
                w_gnt[i] = 1'b1;
            end
        end
    end

    // Result owner decode from the last shadow slot.
    always_comb begin
        w_ret = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_sh_vld[LATENCY-1] && (r_sh_id[LATENCY-1] == IDW'(i))) begin
                w_ret[i] = 1'b1;
            end
        end
    end

    assign w_rr_nxt = (w_gnt_id == IDW'(N_REQ-1)) ? '0 : w_gnt_id + IDW'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy   <= '0;
            r_rr_ptr <= '0;
            r_sh_vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_sh_id[i] <= '0;
            end
        end else begin
            // A returning op and a new issue never target the same requester:
            // the returning one is still busy and therefore not eligible.
            r_busy <= (r_busy & ~w_ret) | w_gnt;
            if (w_issue) begin
                r_rr_ptr <= w_rr_nxt;
            end
            r_sh_vld[0] <= w_issue;
            r_sh_id[0]  <= w_gnt_id;
            for (int i = 1; i < LATENCY; i++) begin
                r_sh_vld[i] <= r_sh_vld[i-1];
                r_sh_id[i]  <= r_sh_id[i-1];
            end
        end
    end

    assign gnt       = w_gnt;
    assign busy      = r_busy;
    assign finv_x    = w_issue ? x_in[32*int'(w_gnt_id) +: 32] : 32'h0;
    assign res_valid = w_ret;
    assign res_y     = finv_y;

`ifdef FINV_ARB_PERF_EN
    int          w_nelig;
    logic [31:0] r_perf_issue;
    logic [31:0] r_perf_conflict;

    always_comb begin
        w_nelig = 0;
        for (int i = 0; i < N_REQ; i++) begin
            w_nelig = w_nelig + int'(w_elig[i]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perf_issue    <= '0;
            r_perf_conflict <= '0;
        end else begin
            if (w_issue) begin
                r_perf_issue <= r_perf_issue + 32'd1;
            end
            if (w_nelig >= 2) begin
                r_perf_conflict <= r_perf_conflict + 32'd1;
            end
        end
    end

    assign perf_issue    = r_perf_issue;
    assign perf_conflict = r_perf_conflict;
`endif

    a_gnt_onehot : assert property (@(posedge clk) disable iff (!rstn) $onehot0(gnt));
    a_res_onehot : assert property (@(posedge clk) disable iff (!rstn) $onehot0(res_valid));
    a_gnt_elig   : assert property (@(posedge clk) disable iff (!rstn) ((gnt & ~(req & ~busy)) == '0));

endmodule

// File: tb/tb_finv_arbiter.sv
module tb_finv_arbiter;
    localparam int N = 4;
    localparam int L = 3;

    logic            clk  = 1'b0;
    logic            rstn = 1'b0;
    logic [N-1:0]    req  = '0;
    logic [32*N-1:0] x_in = '0;
    logic [N-1:0]    gnt, busy, res_valid;
    logic [31:0]     finv_x, finv_y, res_y;
`ifdef FINV_ARB_PERF_EN
    logic [31:0]     perf_issue, perf_conflict;
`endif

    finv_arbiter #(.N_REQ(N), .LATENCY(L)) dut (
        .clk(clk), .rstn(rstn), .req(req), .x_in(x_in),
        .gnt(gnt), .busy(busy), .finv_x(finv_x), .finv_y(finv_y),
        .res_valid(res_valid), .res_y(res_y)
`ifdef FINV_ARB_PERF_EN
        , .perf_issue(perf_issue), .perf_conflict(perf_conflict)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in finv: 3-stage unreset pipe; exact reciprocal for power-of-two operands.
    function automatic logic [31:0] recip(input logic [31:0] x);
        logic [7:0] e;
        e = 8'(254 - int'(x[30:23]));
        return {x[31], e, 23'h0};
    endfunction

    logic [31:0] fp0 = 32'h0, fp1 = 32'h0, fp2 = 32'h0;
    always @(posedge clk) begin
        fp0 <= recip(finv_x);
        fp1 <= fp0;
        fp2 <= fp1;
    end
    assign finv_y = fp2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int          id;
        logic [31:0] y;
        int          c;
    } exp_t;
    exp_t sb[$];

    // Scoreboard: push on each grant, pop on each result; results must land exactly L cycles later.
    always @(negedge clk) begin
        exp_t e;
        int   id;
        if (!rstn) begin
            sb.delete();
            chk("rst_res_valid", 32'(res_valid), 32'h0);
        end else begin
            if (res_valid != '0) begin
                if (sb.size() == 0) begin
                    chk("spurious_res", 32'(res_valid), 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("res_id", 32'(res_valid), 32'(1) << e.id);
                    chk("res_y", res_y, e.y);
                    chk("res_cycle", 32'(cyc), 32'(e.c + L));
                end
            end else if (sb.size() != 0 && sb[0].c + L <= cyc) begin
                e = sb.pop_front();
                chk("res_missing", 32'(res_valid), 32'(1) << e.id);
            end
            if (gnt != '0) begin
                id = 0;
                for (int i = N - 1; i >= 0; i--) if (gnt[i]) id = i;
                e.id = id;
                e.y  = recip(x_in[32*id +: 32]);
                e.c  = cyc;
                sb.push_back(e);
                chk("finv_x", finv_x, x_in[32*id +: 32]);
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req  = '0;
        @(negedge clk);
        nxt();
        rstn = 1'b1;
    endtask

    task automatic drain();
        req = '0;
        repeat (6) nxt();
        chk("sb_drain", 32'(sb.size()), 32'h0);
    endtask

    logic [N-1:0] t2_exp [6];
    logic [N-1:0] t3_exp [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        t2_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        t3_exp = '{4'b0001, 4'b0000, 4'b0000, 4'b1000, 4'b0001};

        // Reset: even with every req high nothing is granted.
        req  = '1;
        x_in = {4{32'h3F800000}};
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_finv_x", finv_x, 32'h0);
        req = '0;
        nxt();
        rstn = 1'b1;

        // 1: single op from requester 2, x = 2.0.
        x_in[64 +: 32] = 32'h40000000;
        req = 4'b0100;
        @(negedge clk);
        chk("t1_gnt", 32'(gnt), 32'h4);
        nxt();
        req = '0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("t1_busy", 32'(busy), 32'h4);
            if (c == 3) begin
                chk("t1_res_valid", 32'(res_valid), 32'h4);
                chk("t1_res_y", res_y, 32'h3F000000);
            end
            nxt();
        end
        @(negedge clk);
        chk("t1_busy_clr", 32'(busy), 32'h0);
        nxt();

        // 2: all four requesting, round robin then reissue as busy clears.
        do_reset();
        x_in = {4{32'h3F800000}};
        req  = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t2_gnt", 32'(gnt), 32'(t2_exp[k]));
            nxt();
        end
        drain();
`ifdef FINV_ARB_PERF_EN
        chk("t2_perf_issue", perf_issue, 32'd6);
        chk("t2_perf_conflict", perf_conflict, 32'd3);
`endif

        // 3: pointer wrap 3 -> 0.
        do_reset();
        x_in = {32'h40000000, 32'h3F800000, 32'h3F800000, 32'h40800000};
        req  = 4'b1000;
        @(negedge clk);
        chk("t3_gnt0", 32'(gnt), 32'h8);
        nxt();
        req = 4'b1001;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_gnt", 32'(gnt), 32'(t3_exp[k]));
            nxt();
        end
        drain();

        // 4: requester 1 holding req: reissue every L+1 cycles.
        do_reset();
        x_in[32 +: 32] = 32'h3E800000;
        req = 4'b0010;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            chk("t4_gnt", 32'(gnt), (c % 4 == 0) ? 32'h2 : 32'h0);
            chk("t4_busy", 32'(busy), (c % 4 == 0) ? 32'h0 : 32'h2);
            nxt();
        end
        drain();

        // 5: reset with two ops in flight.
        do_reset();
        x_in = {4{32'h40000000}};
        req  = 4'b0011;
        @(negedge clk);
        chk("t5_gnt_c0", 32'(gnt), 32'h1);
        nxt();
        @(negedge clk);
        chk("t5_gnt_c1", 32'(gnt), 32'h2);
        nxt();
        rstn = 1'b0;
        @(negedge clk);
        chk("t5_rst_gnt", 32'(gnt), 32'h0);
        chk("t5_rst_busy", 32'(busy), 32'h0);
        nxt();
        rstn = 1'b1;
        req  = '0;
        @(negedge clk);
        chk("t5_c3_res_valid", 32'(res_valid), 32'h0);
        chk("t5_c3_busy", 32'(busy), 32'h0);
        nxt();
        req = 4'b1010;
        @(negedge clk);
        chk("t5_c4_res_valid", 32'(res_valid), 32'h0);
        chk("t5_rr_reset_gnt", 32'(gnt), 32'h2);
        nxt();
        drain();

        // 6: idle.
        req = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t6_gnt", 32'(gnt), 32'h0);
            chk("t6_finv_x", finv_x, 32'h0);
            chk("t6_res_valid", 32'(res_valid), 32'h0);
            nxt();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
